// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter and its clients.
//   - Arbiter grant-state encoding (S_CPU / S_DBG).
//   - DMType access-size encoding, shared with dm and the CPU MEM stage.
//   - dm_access_t: one master's view of the DM port (we/type/addr/data).
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

  // Grant state. Plain constants keep the encoding visible to older tools
  // and to waveform viewers that do not decode enums.
  typedef logic [0:0] arb_state_t;
  localparam arb_state_t S_CPU = 1'b0;
  localparam arb_state_t S_DBG = 1'b1;

  // DMType encoding understood by dm.
  localparam logic [2:0] DM_WORD   = 3'd0;
  localparam logic [2:0] DM_HALF   = 3'd1;
  localparam logic [2:0] DM_HALF_U = 3'd2;
  localparam logic [2:0] DM_BYTE   = 3'd3;
  localparam logic [2:0] DM_BYTE_U = 3'd4;

  // One master's request as presented to the DM port.
  typedef struct packed {
    logic        we;
    logic [2:0]  dtype;
    logic [31:0] addr;
    logic [31:0] data;
  } dm_access_t;

endpackage

// File: rtl/dmem_port_mux.sv
// ----------------------------------------------------------------------------
// dmem_port_mux
//   Purely combinational 2:1 select of the DM port controls between the CPU
//   and the debug master. Only the selected master's fields reach dm, so the
//   non-granted master can never write.
//
// Ports
//   sel_dbg  in   1  1 = debug master owns the port, 0 = CPU
//   cpu      in   dm_access_t  CPU request (we already qualified by cpu_req)
//   dbg      in   dm_access_t  debug request (we already qualified by dbg_req)
//   dm       out  dm_access_t  fields driven to dm
// ----------------------------------------------------------------------------
module dmem_port_mux
  import dmem_arb_pkg::*;
(
  input  logic       sel_dbg,
  input  dm_access_t cpu,
  input  dm_access_t dbg,
  output dm_access_t dm
);

  assign dm = sel_dbg ? dbg : cpu;

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single data-memory port between the CPU MEM stage (master 0,
//   priority) and a debug/loader master (master 1). The grant is registered:
//   a decision taken in one cycle changes the mux select in the next, so
//   there is no combinational path from dbg_req to the DM mux select.
//
//   - While the CPU owns the port, the debug master is granted as soon as
//     the CPU is idle, or after it has waited STARVE_MAX cycles.
//   - While the debug master owns the port, at most BURST_MAX accesses are
//     performed before the port returns to the CPU; a CPU request during
//     the debug grant is stalled.
//   - stall_cnt counts stalled CPU cycles and saturates at all-ones.
//
// Ports
//   clk, rstn                         clock, synchronous active-low reset
//   cpu_req/we/type/addr/wdata   in   CPU MEM-stage access
//   cpu_rdata                    out  load data to CPU
//   cpu_stall                    out  CPU must hold its MEM stage
//   dbg_req/we/type/addr/wdata   in   debug access, held until dbg_ack
//   dbg_burst                    in   another debug access follows this one
//   dbg_ack                      out  debug access performed this cycle
//   dbg_rdata                    out  debug read data (valid with dbg_ack)
//   dm_we/type/addr/din          out  to dm
//   dm_dout                      in   from dm (combinational read)
//   stall_cnt                    out  saturating count of stalled cycles
// ----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8,   // 1..255
  parameter int BURST_MAX  = 4,   // 1..255
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  // CPU MEM stage
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [2:0]       cpu_type,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  // debug / loader master
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [2:0]       dbg_type,
  input  logic [31:0]      dbg_addr,
  input  logic [31:0]      dbg_wdata,
  input  logic             dbg_burst,
  output logic             dbg_ack,
  output logic [31:0]      dbg_rdata,
  // data memory
  output logic             dm_we,
  output logic [2:0]       dm_type,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_din,
  input  logic [31:0]      dm_dout,
  // statistics
  output logic [CNT_W-1:0] stall_cnt
);

  // Last wait count before the debug master is forced in, and the burst
  // limit widened so that burst_cnt + 1 cannot wrap in the comparison.
  localparam logic [7:0] WAIT_LAST = 8'(STARVE_MAX - 1);
  localparam logic [8:0] BURST_LIM = 9'(BURST_MAX);

  arb_state_t  state, state_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic [7:0]  burst_cnt, burst_nxt;
  logic        sel_dbg;
  logic        burst_more;
  dm_access_t  cpu_acc, dbg_acc, dm_acc;

  assign sel_dbg = (state == S_DBG);

  // --------------------------------------------------------------------------
  // DM port select
  // --------------------------------------------------------------------------
  assign cpu_acc = '{we: cpu_req & cpu_we, dtype: cpu_type,
                     addr: cpu_addr, data: cpu_wdata};
  assign dbg_acc = '{we: dbg_req & dbg_we, dtype: dbg_type,
                     addr: dbg_addr, data: dbg_wdata};

  dmem_port_mux u_port_mux (
    .sel_dbg (sel_dbg),
    .cpu     (cpu_acc),
    .dbg     (dbg_acc),
    .dm      (dm_acc)
  );

  // The write strobe is gated by reset so an access caught mid-burst by
  // rstn never reaches memory, even though the grant register only clears
  // at the reset edge.
  assign dm_we   = rstn & dm_acc.we;
  assign dm_type = dm_acc.dtype;
  assign dm_addr = dm_acc.addr;
  assign dm_din  = dm_acc.data;

  // DM read is combinational, so both masters see read data in the same
  // cycle as their access; cpu_rdata is meaningless while stalled.
  assign cpu_rdata = dm_dout;
  assign dbg_rdata = dm_dout;

  assign cpu_stall = sel_dbg & cpu_req;
  // An access abandoned by reset is not acknowledged.
  assign dbg_ack   = rstn & sel_dbg & dbg_req;

  // --------------------------------------------------------------------------
  // Grant FSM and counters
  // --------------------------------------------------------------------------
  assign burst_more = ({1'b0, burst_cnt} + 9'd1) < BURST_LIM;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    state_nxt = state;
    wait_nxt  = wait_cnt;
    burst_nxt = burst_cnt;
    case (state)
      S_CPU: begin
        burst_nxt = '0;
        if (dbg_req && (!cpu_req || wait_cnt == WAIT_LAST)) begin
          state_nxt = S_DBG;
          wait_nxt  = '0;
        end else if (dbg_req) begin
          wait_nxt = wait_cnt + 8'd1;
        end else begin
          wait_nxt = '0;
        end
      end
      S_DBG: begin
        wait_nxt = '0;
        if (dbg_req && dbg_burst && burst_more) begin
          burst_nxt = burst_cnt + 8'd1;
        end else begin
          // Either the burst cap is reached, the master has nothing more
          // queued, or it dropped its request: hand the port back.
          state_nxt = S_CPU;
          burst_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_CPU;
        wait_nxt  = '0;
        burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rstn) begin
      state     <= S_CPU;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
      if (cpu_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. A small behavioural dm (sync write,
//   combinational read) sits on the DM port. Stimulus tasks push the
//   expected response of each debug access / CPU load into queues; a
//   negedge monitor pops and compares whenever the DUT acknowledges.
//   stall_cnt is 3 bits wide here so its saturation is reached.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int STARVE_MAX = 8;
  localparam int BURST_MAX  = 4;
  localparam int CNT_W      = 3;

  logic             clk;
  logic             rstn;
  logic             cpu_req, cpu_we;
  logic [2:0]       cpu_type;
  logic [31:0]      cpu_addr, cpu_wdata, cpu_rdata;
  logic             cpu_stall;
  logic             dbg_req, dbg_we, dbg_burst, dbg_ack;
  logic [2:0]       dbg_type;
  logic [31:0]      dbg_addr, dbg_wdata, dbg_rdata;
  logic             dm_we;
  logic [2:0]       dm_type;
  logic [31:0]      dm_addr, dm_din, dm_dout;
  logic [CNT_W-1:0] stall_cnt;

  dmem_arbiter #(
    .STARVE_MAX (STARVE_MAX),
    .BURST_MAX  (BURST_MAX),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_type  (cpu_type),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_type  (dbg_type),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_burst (dbg_burst),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .dm_we     (dm_we),
    .dm_type   (dm_type),
    .dm_addr   (dm_addr),
    .dm_din    (dm_din),
    .dm_dout   (dm_dout),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Behavioural data memory (64 words)
  // --------------------------------------------------------------------------
  logic [31:0] mem [0:63];
  logic [31:0] rd_word;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;

  assign rd_word = mem[dm_addr[7:2]];
  assign rd_half = dm_addr[1] ? rd_word[31:16] : rd_word[15:0];
  assign rd_byte = rd_word[{dm_addr[1:0], 3'b000} +: 8];

  always_comb begin
    case (dm_type)
      DM_HALF:   dm_dout = {{16{rd_half[15]}}, rd_half};
      DM_HALF_U: dm_dout = {16'h0, rd_half};
      DM_BYTE:   dm_dout = {{24{rd_byte[7]}}, rd_byte};
      DM_BYTE_U: dm_dout = {24'h0, rd_byte};
      default:   dm_dout = rd_word;
    endcase
  end

  always @(posedge clk) begin
    if (dm_we) begin
      case (dm_type)
        DM_HALF, DM_HALF_U:
          mem[dm_addr[7:2]][{dm_addr[1], 4'b0000} +: 16] <= dm_din[15:0];
        DM_BYTE, DM_BYTE_U:
          mem[dm_addr[7:2]][{dm_addr[1:0], 3'b000} +: 8] <= dm_din[7:0];
        default:
          mem[dm_addr[7:2]] <= dm_din;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } dbg_exp_t;

  dbg_exp_t    dbg_q [$];
  logic [31:0] cpu_q [$];
  dbg_exp_t    mon_e;
  logic [31:0] mon_cpu;
  int          run_len = 0;
  int          max_run = 0;

  // Scoreboard monitor: compares each acknowledged debug access and each
  // completed CPU load against the queued expectation; tracks the longest
  // run of consecutive CPU stall cycles.
  always @(negedge clk) begin
    if (rstn) begin
      if (dbg_ack) begin
        if (dbg_q.size() == 0) begin
          check("dbg_ack_unexpected", 32'(dbg_ack), 32'd0);
        end else begin
          mon_e = dbg_q.pop_front();
          if (mon_e.we) check("dbg_write_strobe", 32'(dm_we), 32'd1);
          else          check("dbg_rdata", dbg_rdata, mon_e.data);
        end
      end
      if (cpu_req && !cpu_we && !cpu_stall) begin
        if (cpu_q.size() == 0) begin
          check("cpu_load_unexpected", 32'(cpu_req), 32'd0);
        end else begin
          mon_cpu = cpu_q.pop_front();
          check("cpu_rdata", cpu_rdata, mon_cpu);
        end
      end
      if (cpu_stall) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end else begin
      run_len = 0;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 ns after the rising edge)
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One debug word access. lat = cycles seen without ack before the ack.
  // Returns just after the edge that consumes the ack, request still high.
  task automatic dbg_op(input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic burst,
                        input logic [31:0] exp_rd, output int lat);
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_type  = DM_WORD;
    dbg_addr  = addr;
    dbg_wdata = data;
    dbg_burst = burst;
    dbg_q.push_back('{we: we, data: exp_rd});
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (dbg_ack) break;
      lat++;
      if (lat > 40) begin
        check("dbg_ack_timeout", 32'(dbg_ack), 32'd1);
        break;
      end
    end
    tick();
  endtask

  // One CPU access held until not stalled. stalls = stalled cycles seen.
  task automatic cpu_op(input logic we, input logic [2:0] t,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_rd, output int stalls);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_type  = t;
    cpu_addr  = addr;
    cpu_wdata = data;
    if (!we) cpu_q.push_back(exp_rd);
    stalls = 0;
    while (1) begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
      if (stalls > 40) begin
        check("cpu_stall_timeout", 32'(cpu_stall), 32'd0);
        break;
      end
    end
    tick();
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  int lat_idle  [6] = '{1, 0, 0, 0, 1, 0};
  int lat_busy  [6] = '{8, 0, 0, 0, 8, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int stalls;

    // Reset with a CPU store presented: nothing may reach dm.
    rstn = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_type = DM_WORD;
    cpu_addr = 32'h30; cpu_wdata = 32'h5555_5555;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_type = DM_WORD;
    dbg_addr = 32'h0; dbg_wdata = 32'h0; dbg_burst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("reset_dm_we", 32'(dm_we), 32'd0);
    check("reset_cpu_stall", 32'(cpu_stall), 32'd0);
    check("reset_dbg_ack", 32'(dbg_ack), 32'd0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rstn = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;

    // 1: idle CPU, debug write then read back.
    dbg_op(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, lat);
    check("t1_write_latency", 32'(lat), 32'd1);
    dbg_req = 1'b0;
    dbg_op(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, lat);
    check("t1_read_latency", 32'(lat), 32'd1);
    dbg_req = 1'b0;
    @(negedge clk);
    check("t1_stall_cnt", 32'(stall_cnt), 32'd0);
    check("t1_no_stall", 32'(max_run), 32'd0);
    tick();

    // 2: CPU busy every cycle; debug waits STARVE_MAX cycles.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_type = DM_WORD;
    cpu_addr = 32'h30; cpu_wdata = 32'h1111_1111;
    dbg_op(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, lat);
    check("t2_starve_latency", 32'(lat), 32'd8);
    dbg_req = 1'b0;
    @(negedge clk);
    check("t2_cpu_regains", 32'(cpu_stall), 32'd0);
    check("t2_stall_cnt", 32'(stall_cnt), 32'd1);
    check("t2_stall_run", 32'(max_run), 32'd1);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;

    // 3a: six-access write burst with an idle CPU; cap splits it 4 + 2.
    for (int i = 0; i < 6; i++) begin
      dbg_op(1'b1, 32'h40 + 32'(4 * i), 32'hB000_0000 + 32'(i), (i < 5),
             32'h0, lat);
      check($sformatf("t3a_latency_%0d", i), 32'(lat), 32'(lat_idle[i]));
    end
    dbg_req = 1'b0;

    // 3b: read the burst back while the CPU stores every cycle.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_type = DM_WORD;
    cpu_addr = 32'h30; cpu_wdata = 32'h1111_1111;
    for (int i = 0; i < 6; i++) begin
      dbg_op(1'b0, 32'h40 + 32'(4 * i), 32'h0, (i < 5),
             32'hB000_0000 + 32'(i), lat);
      check($sformatf("t3b_latency_%0d", i), 32'(lat), 32'(lat_busy[i]));
    end
    dbg_req = 1'b0;
    @(negedge clk);
    check("t3b_stall_cnt", 32'(stall_cnt), 32'd7);
    check("t3b_longest_stall", 32'(max_run), 32'd4);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;

    // 4: CPU byte store arriving in the grant cycle is held, then lands.
    fork
      begin
        dbg_op(1'b1, 32'h20, 32'h0, 1'b0, 32'h0, lat);
        dbg_req = 1'b0;
      end
      begin
        tick();
        cpu_op(1'b1, DM_BYTE, 32'h21, 32'h0000_00AA, 32'h0, stalls);
      end
    join
    check("t4_dbg_latency", 32'(lat), 32'd1);
    check("t4_store_stalls", 32'(stalls), 32'd1);
    cpu_op(1'b0, DM_WORD, 32'h20, 32'h0, 32'h0000_AA00, stalls);
    check("t4_load_stalls", 32'(stalls), 32'd0);
    @(negedge clk);
    check("t4_stall_cnt_saturated", 32'(stall_cnt), 32'd7);
    tick();

    // 5: reset in the middle of a write burst.
    dbg_op(1'b1, 32'h60, 32'h1234_5678, 1'b0, 32'h0, lat);
    dbg_req = 1'b0;
    dbg_op(1'b1, 32'h64, 32'hAAAA_0001, 1'b1, 32'h0, lat);
    check("t5_burst_latency", 32'(lat), 32'd1);
    dbg_we = 1'b1; dbg_addr = 32'h60; dbg_wdata = 32'hBAD0_BAD0;
    rstn = 1'b0;
    @(negedge clk);
    check("t5_reset_dm_we", 32'(dm_we), 32'd0);
    tick();
    rstn = 1'b1; dbg_req = 1'b0; dbg_burst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_type = DM_WORD;
    cpu_addr = 32'h30; cpu_wdata = 32'h2222_2222;
    @(negedge clk);
    check("t5_cpu_owns_port", 32'(cpu_stall), 32'd0);
    check("t5_cpu_store_strobe", 32'(dm_we), 32'd1);
    check("t5_stall_cnt_cleared", 32'(stall_cnt), 32'd0);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    dbg_op(1'b0, 32'h60, 32'h0, 1'b0, 32'h1234_5678, lat);
    dbg_req = 1'b0;

    // 6: debug drops its request while granted.
    dbg_op(1'b1, 32'h74, 32'h0BAD_CAFE, 1'b1, 32'h0, lat);
    dbg_req = 1'b0; dbg_burst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_type = DM_WORD;
    cpu_addr = 32'h70; cpu_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("t6_no_ack", 32'(dbg_ack), 32'd0);
    check("t6_dm_we_off", 32'(dm_we), 32'd0);
    check("t6_cpu_stalled", 32'(cpu_stall), 32'd1);
    tick();
    @(negedge clk);
    check("t6_cpu_regains", 32'(cpu_stall), 32'd0);
    check("t6_cpu_store_strobe", 32'(dm_we), 32'd1);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_op(1'b0, DM_WORD, 32'h70, 32'h0, 32'hCAFE_F00D, stalls);
    dbg_op(1'b0, 32'h74, 32'h0, 1'b0, 32'h0BAD_CAFE, lat);
    dbg_req = 1'b0;
    @(negedge clk);
    check("t6_stall_cnt", 32'(stall_cnt), 32'd1);

    tick();
    check("dbg_queue_drained", 32'(dbg_q.size()), 32'd0);
    check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    check("stall_run_within_cap", 32'(max_run <= BURST_MAX), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
